y86_stage_ctrl: RTL and testbench

Y86_STAGE_CTRL -- requirements
Module: y86_stage_ctrl

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_stage_ctrl_if.sv | 27 ++
 rtl/y86_stage_ctrl.sv | 110 +++++++++++
 tb/tb_y86_stage_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared types and constants for the Y86 sequential stage controller:
// controller states, processor status codes and the instruction codes it inspects.
package y86_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEMORY,
      ST_WRITEBACK,
      ST_PCUPD,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   // Instructions that touch data memory in the MEMORY stage.
   function automatic logic is_mem_icode(input logic [3:0] icode);
      return (icode == ICODE_RMMOVQ) || (icode == ICODE_MRMOVQ) ||
             (icode == ICODE_CALL)   || (icode == ICODE_RET)    ||
             (icode == ICODE_PUSHQ)  || (icode == ICODE_POPQ);
   endfunction

endpackage

// File: rtl/y86_stage_ctrl_if.sv
// Handshake bundle between the stage controller (master) and the fetch/memory
// datapath that feeds it (slave).
interface y86_stage_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic [3:0]       icode;
   logic             instr_valid;
   logic             imem_error;
   logic             dmem_error;
   logic             mem_ready;
   logic [5:0]       stage_en;
   logic             mem_req;
   logic             pc_we;
   logic [2:0]       stat;
   logic [CNT_W-1:0] retired;

   modport master (
      input  start, icode, instr_valid, imem_error, dmem_error, mem_ready,
      output stage_en, mem_req, pc_we, stat, retired
   );

   modport slave (
      output start, icode, instr_valid, imem_error, dmem_error, mem_ready,
      input  stage_en, mem_req, pc_we, stat, retired
   );
endinterface

// File: rtl/y86_stage_ctrl.sv
// Sequential Y86 controller: steps one instruction through FETCH..PCUPD, waits on
// data memory with a timeout, and halts with a status code on faults or HALT.
module y86_stage_ctrl
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   y86_stage_ctrl_if.master bus
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   stat_e            stat_q, stat_d;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         stat_q    <= STAT_AOK;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         stat_q    <= stat_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      stat_d    = stat_q;
      wait_d    = '0;
      retired_d = retired_q;
      unique case (state_q)
         ST_IDLE:    if (bus.start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (bus.imem_error) begin
               state_d = ST_HALT;
               stat_d  = STAT_ADR;
            end else if (!bus.instr_valid) begin
               state_d = ST_HALT;
               stat_d  = STAT_INS;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE:  state_d = ST_EXECUTE;
         ST_EXECUTE: state_d = ST_MEMORY;
         ST_MEMORY: begin
            if (!is_mem_icode(bus.icode)) begin
               state_d = ST_WRITEBACK;
            end else if (bus.mem_ready) begin
               state_d = bus.dmem_error ? ST_HALT : ST_WRITEBACK;
               if (bus.dmem_error) stat_d = STAT_ADR;
            end else if (wait_q == WAIT_LAST) begin
               // Last permitted wait cycle expired without a response.
               state_d = ST_HALT;
               stat_d  = STAT_ADR;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         ST_WRITEBACK: state_d = ST_PCUPD;
         ST_PCUPD: begin
            retired_d = retired_q + CNT_W'(1);
            if (bus.icode == ICODE_HALT) begin
               state_d = ST_HALT;
               stat_d  = STAT_HLT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.stage_en = 6'b000000;
      bus.mem_req  = 1'b0;
      bus.pc_we    = 1'b0;
      unique case (state_q)
         ST_FETCH:     bus.stage_en = 6'b000001;
         ST_DECODE:    bus.stage_en = 6'b000010;
         ST_EXECUTE:   bus.stage_en = 6'b000100;
         ST_MEMORY: begin
            bus.stage_en = 6'b001000;
            bus.mem_req  = is_mem_icode(bus.icode);
         end
         ST_WRITEBACK: bus.stage_en = 6'b010000;
         ST_PCUPD: begin
            bus.stage_en = 6'b100000;
            bus.pc_we    = 1'b1;
         end
         default:      bus.stage_en = 6'b000000;
      endcase
   end

   assign bus.stat    = stat_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_y86_stage_ctrl.sv
// Self-checking bench for y86_stage_ctrl: a cycle model of the instruction sequence
// checked every cycle, plus directed scenarios with literal expectations.
module tb_y86_stage_ctrl;

   localparam int TB_TIMEOUT = 15;
   localparam logic [5:0] EN_MEM = 6'b001000;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   y86_stage_ctrl_if #(.CNT_W(32)) bus ();

   y86_stage_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Model: phase 0 idle, 1..6 = fetch,decode,execute,memory,writeback,pcupd; 7 halted.
   int          m_phase;
   int unsigned m_wait;
   logic [2:0]  m_stat;
   logic [31:0] m_retired;

   function automatic bit uses_mem(input logic [3:0] ic);
      return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   <= 0;
         m_wait    <= 0;
         m_stat    <= 3'd1;
         m_retired <= '0;
      end else begin
         case (m_phase)
            0: if (bus.start) m_phase <= 1;
            1: begin
               if (bus.imem_error)       begin m_phase <= 7; m_stat <= 3'd3; end
               else if (!bus.instr_valid) begin m_phase <= 7; m_stat <= 3'd4; end
               else m_phase <= 2;
            end
            2: m_phase <= 3;
            3: begin m_phase <= 4; m_wait <= 0; end
            4: begin
               if (!uses_mem(bus.icode)) m_phase <= 5;
               else if (bus.mem_ready) begin
                  if (bus.dmem_error) begin m_phase <= 7; m_stat <= 3'd3; end
                  else m_phase <= 5;
               end else if (m_wait + 1 == TB_TIMEOUT) begin
                  m_phase <= 7;
                  m_stat  <= 3'd3;
               end else m_wait <= m_wait + 1;
            end
            5: m_phase <= 6;
            6: begin
               m_retired <= m_retired + 1;
               if (bus.icode == 4'h0) begin m_phase <= 7; m_stat <= 3'd2; end
               else m_phase <= 1;
            end
            default: m_phase <= m_phase;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [5:0] exp_en;
      exp_en = (m_phase >= 1 && m_phase <= 6) ? 6'(1 << (m_phase - 1)) : 6'b0;
      if (rst_n) begin
         check("model_stage_en", 64'(bus.stage_en), 64'(exp_en));
         check("model_mem_req", 64'(bus.mem_req), 64'(m_phase == 4 && uses_mem(bus.icode)));
         check("model_pc_we", 64'(bus.pc_we), 64'(m_phase == 6));
         check("model_stat", 64'(bus.stat), 64'(m_stat));
         check("model_retired", 64'(bus.retired), 64'(m_retired));
      end
   end

   task automatic set_in(input logic s, input logic [3:0] ic, input logic v,
                         input logic im, input logic dm, input logic rd);
      bus.start       = s;
      bus.icode       = ic;
      bus.instr_valid = v;
      bus.imem_error  = im;
      bus.dmem_error  = dm;
      bus.mem_ready   = rd;
   endtask

   // Pulses reset between edges; the next negedge sees the IDLE cycle.
   task automatic reset_with(input logic s, input logic [3:0] ic, input logic v,
                             input logic im, input logic dm, input logic rd);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      set_in(s, ic, v, im, dm, rd);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int pw;
      int mem_cycles;
      int req_cycles;
      logic [5:0] exp_en;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);

      // Plain instruction with immediate memory: one-hot walk, single pc_we, retire once.
      reset_with(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("rst_stage_en", 64'(bus.stage_en), 64'h0);
      check("rst_stat", 64'(bus.stat), 64'h1);
      check("rst_retired", 64'(bus.retired), 64'h0);
      check("rst_mem_req", 64'(bus.mem_req), 64'h0);
      pw = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         exp_en = (i < 6) ? 6'(1 << i) : 6'b000001;
         check("walk_stage_en", 64'(bus.stage_en), 64'(exp_en));
         if (bus.pc_we) pw++;
         if (i == 5) check("walk_retired_pcupd", 64'(bus.retired), 64'h0);
      end
      check("walk_pc_we_pulses", 64'(pw), 64'h1);
      check("walk_retired", 64'(bus.retired), 64'h1);

      // MRMOVQ with mem_ready low for three cycles.
      reset_with(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      mem_cycles = 0;
      req_cycles = 0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.stage_en == EN_MEM) mem_cycles++;
         if (bus.mem_req) req_cycles++;
         bus.mem_ready = (k >= 3);
      end
      check("wait_mem_cycles", 64'(mem_cycles), 64'd4);
      check("wait_req_cycles", 64'(req_cycles), 64'd4);
      check("wait_retired", 64'(bus.retired), 64'h1);
      check("wait_refetch", 64'(bus.stage_en), 64'h1);

      // RMMOVQ that never gets mem_ready: timeout fault.
      reset_with(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      mem_cycles = 0;
      pw = 0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.stage_en == EN_MEM) mem_cycles++;
         if (bus.pc_we) pw++;
      end
      check("tmo_mem_cycles", 64'(mem_cycles), 64'd15);
      check("tmo_stat", 64'(bus.stat), 64'h3);
      check("tmo_halted", 64'(bus.stage_en), 64'h0);
      check("tmo_pc_we", 64'(pw), 64'h0);
      check("tmo_retired", 64'(bus.retired), 64'h0);

      // Fetch faults: imem_error beats instr_valid=0; invalid alone gives INS.
      reset_with(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("fetch_adr_stat", 64'(bus.stat), 64'h3);
      check("fetch_adr_halt", 64'(bus.stage_en), 64'h0);
      reset_with(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("fetch_ins_stat", 64'(bus.stat), 64'h4);

      // Data memory fault reported with mem_ready.
      reset_with(1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      check("dmem_stat", 64'(bus.stat), 64'h3);
      check("dmem_retired", 64'(bus.retired), 64'h0);

      // HALT instruction retires, then the controller ignores everything.
      reset_with(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (7) @(negedge clk);
      check("hlt_pc_we", 64'(bus.pc_we), 64'h1);
      @(negedge clk);
      check("hlt_stat", 64'(bus.stat), 64'h2);
      check("hlt_retired", 64'(bus.retired), 64'h1);
      set_in(1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      check("hlt_hold_stage", 64'(bus.stage_en), 64'h0);
      check("hlt_hold_stat", 64'(bus.stat), 64'h2);
      check("hlt_hold_retired", 64'(bus.retired), 64'h1);

      // Asynchronous reset while a memory request is outstanding.
      reset_with(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1;
      bus.icode     = 4'h5;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("arst_pre_retired", 64'(bus.retired), 64'h1);
      repeat (3) @(negedge clk);
      check("arst_pre_mem_req", 64'(bus.mem_req), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mem_req", 64'(bus.mem_req), 64'h0);
      check("arst_stage_en", 64'(bus.stage_en), 64'h0);
      check("arst_retired", 64'(bus.retired), 64'h0);
      check("arst_stat", 64'(bus.stat), 64'h1);
      check("arst_pc_we", 64'(bus.pc_we), 64'h0);
      #20;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
